acc_offload_tracker: RTL and testbench



---
 rtl/acc_pkg.sv | 28 ++
 rtl/acc_rd_scoreboard.sv | 49 ++++
 rtl/acc_offload_tracker.sv | 157 +++++++++++++++
 tb/tb_acc_offload_tracker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants and types for the accelerator offload adapter.
// Register-field positions in the offered instruction plus the debug stall-cause encoding.
package acc_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned RD_LSB    = 7;
    localparam int unsigned RS1_LSB   = 15;
    localparam int unsigned RS2_LSB   = 20;
    localparam int unsigned RS3_LSB   = 27;

    typedef enum logic [2:0] {
        STALL_NONE,
        STALL_RS_INVALID,
        STALL_RAW,
        STALL_WAW,
        STALL_FULL,
        STALL_OUTST
    } acc_offl_stall_e;

    function automatic int unsigned rs_lsb(input int unsigned j);
        case (j)
            0:       return RS1_LSB;
            1:       return RS2_LSB;
            default: return RS3_LSB;
        endcase
    endfunction

endpackage

// File: rtl/acc_rd_scoreboard.sv
// Destination-register scoreboard: one pending bit per architectural register
// plus a count of in-flight writeback offloads.
module acc_rd_scoreboard
    import acc_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    output logic [31:0]          pending_o,
    output logic                 outst_full_o
);

    localparam int unsigned OW = $clog2(MaxOutstanding + 1);

    logic [31:0]   pending_q, pending_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          set_hit, clr_hit;

    // A clear only counts if the id is actually in flight; stale ids are ignored.
    assign clr_hit = clr_i & pending_q[clr_idx_i];
    assign set_hit = set_i & (set_idx_i != '0);

    always_comb begin
        pending_d = pending_q;
        if (clr_hit) pending_d[clr_idx_i] = 1'b0;
        if (set_hit) pending_d[set_idx_i] = 1'b1;
        pending_d[0] = 1'b0;
        outst_d = outst_q + OW'(set_hit) - OW'(clr_hit);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            outst_q   <= '0;
        end else begin
            pending_q <= pending_d;
            outst_q   <= outst_d;
        end
    end

    assign pending_o    = pending_q;
    assign outst_full_o = (outst_q == OW'(MaxOutstanding));

endmodule

// File: rtl/acc_offload_tracker.sv
// Offload adapter: predecoder selection, hazard stalls against the rd scoreboard,
// a registered request ring buffer, and a pass-through response path.
module acc_offload_tracker
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned NumRs          = 3,
    parameter int unsigned NumRspTot      = 8,
    parameter int unsigned AddrWidth      = $clog2(NumRspTot),
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [31:0]                    instr_i,
    input  logic [NumRs*DataWidth-1:0]     rs_i,
    input  logic [NumRs-1:0]               rs_valid_i,
    input  logic                           q_valid_i,
    output logic                           q_ready_o,
    output logic                           accept_o,
    output logic                           writeback_o,
    input  logic [NumRspTot-1:0]           offload_accept_i,
    input  logic [NumRspTot*NumRs-1:0]     use_rs_i,
    input  logic [NumRspTot-1:0]           pd_writeback_i,
    output logic                           acc_q_valid_o,
    input  logic                           acc_q_ready_i,
    output logic [AddrWidth-1:0]           acc_q_addr_o,
    output logic [31:0]                    acc_q_op_o,
    output logic [NumRs*DataWidth-1:0]     acc_q_arg_o,
    output logic [4:0]                     acc_q_id_o,
    input  logic                           acc_p_valid_i,
    output logic                           acc_p_ready_o,
    input  logic [4:0]                     acc_p_id_i,
    input  logic [DataWidth-1:0]           acc_p_data_i,
    input  logic                           acc_p_error_i,
    output logic                           p_valid_o,
    input  logic                           p_ready_i,
    output logic [4:0]                     p_id_o,
    output logic [DataWidth-1:0]           p_data_o,
    output logic                           p_error_o,
    output logic                           multi_accept_err_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic [AddrWidth-1:0]       addr;
        logic [31:0]                op;
        logic [NumRs*DataWidth-1:0] args;
        logic [4:0]                 id;
    } req_t;

    logic [AddrWidth-1:0] sel;
    logic [NumRs-1:0]     use_rs;
    logic [4:0]           rd;
    logic [31:0]          pending;
    logic                 outst_full;
    logic                 rs_invalid, raw_hit, waw_hit, fifo_full;
    acc_offl_stall_e      stall_cause;
    logic                 push, pop;
    logic                 multi_err_q, multi_err_d;

    req_t                 mem_q [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    // Lowest-index claim wins when several predecoders fire.
    always_comb begin
        sel = '0;
        for (int i = NumRspTot - 1; i >= 0; i--) begin
            if (offload_accept_i[i]) sel = AddrWidth'(i);
        end
    end

    assign accept_o    = |offload_accept_i;
    assign writeback_o = accept_o & pd_writeback_i[sel];
    assign use_rs      = use_rs_i[sel*NumRs +: NumRs];
    assign rd          = instr_i[RD_LSB +: REG_IDX_W];
    assign fifo_full   = (count_q == CntW'(FifoDepth));

    always_comb begin
        rs_invalid = 1'b0;
        raw_hit    = 1'b0;
        for (int j = 0; j < NumRs; j++) begin
            if (use_rs[j] && !rs_valid_i[j]) rs_invalid = 1'b1;
            if (use_rs[j] && pending[instr_i[rs_lsb(j) +: REG_IDX_W]]) raw_hit = 1'b1;
        end
        waw_hit = writeback_o & pending[rd];

        stall_cause = STALL_NONE;
        if (rs_invalid)                                  stall_cause = STALL_RS_INVALID;
        else if (raw_hit)                                stall_cause = STALL_RAW;
        else if (waw_hit)                                stall_cause = STALL_WAW;
        else if (fifo_full)                              stall_cause = STALL_FULL;
        else if (writeback_o && rd != '0 && outst_full)  stall_cause = STALL_OUTST;
    end

    assign q_ready_o = !accept_o || (stall_cause == STALL_NONE);
    assign push      = q_valid_i & q_ready_o & accept_o;
    assign pop       = acc_q_valid_o & acc_q_ready_i;

    acc_rd_scoreboard #(
        .MaxOutstanding(MaxOutstanding)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (push & writeback_o),
        .set_idx_i   (rd),
        .clr_i       (acc_p_valid_i & p_ready_i),
        .clr_idx_i   (acc_p_id_i),
        .pending_o   (pending),
        .outst_full_o(outst_full)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
        count_d     = count_q + CntW'(push) - CntW'(pop);
        multi_err_d = multi_err_q | (q_valid_i & ($countones(offload_accept_i) > 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            multi_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            multi_err_q <= multi_err_d;
        end
    end

    // Storage needs no reset; the empty flag masks stale contents on the outputs.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: sel, op: instr_i, args: rs_i, id: rd};
    end

    assign acc_q_valid_o      = (count_q != '0);
    assign acc_q_addr_o       = acc_q_valid_o ? mem_q[rd_ptr_q].addr : '0;
    assign acc_q_op_o         = acc_q_valid_o ? mem_q[rd_ptr_q].op   : '0;
    assign acc_q_arg_o        = acc_q_valid_o ? mem_q[rd_ptr_q].args : '0;
    assign acc_q_id_o         = acc_q_valid_o ? mem_q[rd_ptr_q].id   : '0;
    assign multi_accept_err_o = multi_err_q;

    assign p_valid_o     = acc_p_valid_i;
    assign acc_p_ready_o = p_ready_i;
    assign p_id_o        = acc_p_id_i;
    assign p_data_o      = acc_p_data_i;
    assign p_error_o     = acc_p_error_i;

endmodule

// File: tb/tb_acc_offload_tracker.sv
// Directed bench for acc_offload_tracker with default parameters
// (NumRs=3, NumRspTot=8, FifoDepth=2, MaxOutstanding=4).
module tb_acc_offload_tracker;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic [95:0] rs_i;
    logic [2:0]  rs_valid_i;
    logic        q_valid_i;
    logic        q_ready_o, accept_o, writeback_o;
    logic [7:0]  offload_accept_i;
    logic [23:0] use_rs_i;
    logic [7:0]  pd_writeback_i;
    logic        acc_q_valid_o, acc_q_ready_i;
    logic [2:0]  acc_q_addr_o;
    logic [31:0] acc_q_op_o;
    logic [95:0] acc_q_arg_o;
    logic [4:0]  acc_q_id_o;
    logic        acc_p_valid_i, acc_p_ready_o;
    logic [4:0]  acc_p_id_i;
    logic [31:0] acc_p_data_i;
    logic        acc_p_error_i;
    logic        p_valid_o, p_ready_i;
    logic [4:0]  p_id_o;
    logic [31:0] p_data_o;
    logic        p_error_o;
    logic        multi_accept_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    acc_offload_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .rs_i(rs_i),
        .rs_valid_i(rs_valid_i), .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
        .accept_o(accept_o), .writeback_o(writeback_o),
        .offload_accept_i(offload_accept_i), .use_rs_i(use_rs_i),
        .pd_writeback_i(pd_writeback_i), .acc_q_valid_o(acc_q_valid_o),
        .acc_q_ready_i(acc_q_ready_i), .acc_q_addr_o(acc_q_addr_o),
        .acc_q_op_o(acc_q_op_o), .acc_q_arg_o(acc_q_arg_o), .acc_q_id_o(acc_q_id_o),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
        .acc_p_id_i(acc_p_id_i), .acc_p_data_i(acc_p_data_i),
        .acc_p_error_i(acc_p_error_i), .p_valid_o(p_valid_o), .p_ready_i(p_ready_i),
        .p_id_o(p_id_o), .p_data_o(p_data_o), .p_error_o(p_error_o),
        .multi_accept_err_o(multi_accept_err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 1ns after that.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int rs3);
        return {5'(rs3), 2'b00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h0b};
    endfunction

    task automatic offer(input int pd, input bit wb, input logic [2:0] use_rs, input logic [31:0] instr);
        offload_accept_i = 8'd1 << pd;
        pd_writeback_i   = wb ? (8'd1 << pd) : 8'd0;
        use_rs_i         = 24'(use_rs) << (pd * 3);
        instr_i          = instr;
        q_valid_i        = 1'b1;
    endtask

    task automatic idle();
        q_valid_i        = 1'b0;
        offload_accept_i = '0;
        pd_writeback_i   = '0;
        use_rs_i         = '0;
    endtask

    localparam logic [95:0] RS_VALS = {32'hcccc_0003, 32'hbbbb_0002, 32'haaaa_0001};

    initial begin
        rst_i = 1'b1; instr_i = '0; rs_i = RS_VALS; rs_valid_i = 3'b111;
        acc_q_ready_i = 1'b1; acc_p_valid_i = 1'b0; acc_p_id_i = '0;
        acc_p_data_i = '0; acc_p_error_i = 1'b0; p_ready_i = 1'b1;
        idle();
        cyc(); cyc();
        chk("rst_acc_q_valid", acc_q_valid_o, 0);
        chk("rst_multi_err", multi_accept_err_o, 0);
        chk("rst_acc_q_op", acc_q_op_o, 0);
        chk("rst_acc_q_id", acc_q_id_o, 0);
        rst_i = 1'b0;
        cyc();

        // Writeback to rd=5 via predecoder 2
        offer(2, 1, 3'b000, mk(5, 0, 0, 0)); #1;
        chk("wb_accept", accept_o, 1);
        chk("wb_writeback", writeback_o, 1);
        chk("wb_q_ready", q_ready_o, 1);
        cyc();
        idle(); #1;
        chk("wb_acc_q_valid", acc_q_valid_o, 1);
        chk("wb_acc_q_id", acc_q_id_o, 5);
        chk("wb_acc_q_addr", acc_q_addr_o, 2);
        chk("wb_acc_q_op", acc_q_op_o, mk(5, 0, 0, 0));
        chk("wb_acc_q_arg", acc_q_arg_o, RS_VALS);
        offer(0, 0, 3'b001, mk(1, 5, 0, 0)); #1;
        chk("raw_stall", q_ready_o, 0);
        offer(0, 1, 3'b000, mk(5, 0, 0, 0)); #1;
        chk("waw_stall", q_ready_o, 0);
        rs_valid_i = 3'b101;
        offer(0, 0, 3'b010, mk(1, 0, 0, 0)); #1;
        chk("rs_invalid_stall", q_ready_o, 0);
        rs_valid_i = 3'b111;
        offer(0, 0, 3'b001, mk(1, 5, 0, 0));
        cyc();
        acc_p_valid_i = 1'b1; acc_p_id_i = 5'd5; acc_p_data_i = 32'h1234_5678; acc_p_error_i = 1'b1; #1;
        chk("rsp_p_valid", p_valid_o, 1);
        chk("rsp_p_id", p_id_o, 5);
        chk("rsp_p_data", p_data_o, 32'h1234_5678);
        chk("rsp_p_error", p_error_o, 1);
        chk("rsp_acc_p_ready", acc_p_ready_o, 1);
        chk("rsp_no_bypass", q_ready_o, 0);
        chk("rsp_popped", acc_q_valid_o, 0);
        cyc();
        acc_p_valid_i = 1'b0; acc_p_error_i = 1'b0; #1;
        chk("raw_lifted", q_ready_o, 1);
        cyc();
        idle(); #1;
        chk("raw_push_valid", acc_q_valid_o, 1);
        chk("raw_push_op", acc_q_op_o, mk(1, 5, 0, 0));
        cyc();
        chk("drain_empty", acc_q_valid_o, 0);

        // Buffer full with the interconnect stalled
        acc_q_ready_i = 1'b0;
        offer(1, 0, 3'b000, mk(10, 0, 0, 0)); #1;
        chk("fifo_a_ready", q_ready_o, 1);
        cyc();
        offer(1, 0, 3'b000, mk(11, 0, 0, 0)); #1;
        chk("fifo_b_ready", q_ready_o, 1);
        cyc();
        offer(1, 0, 3'b000, mk(12, 0, 0, 0)); #1;
        chk("fifo_full_stall", q_ready_o, 0);
        chk("fifo_head_a", acc_q_op_o, mk(10, 0, 0, 0));
        cyc();
        chk("fifo_hold_a", acc_q_op_o, mk(10, 0, 0, 0));
        acc_q_ready_i = 1'b1; #1;
        chk("fifo_full_prepop", q_ready_o, 0);
        cyc();
        chk("fifo_after_pop", q_ready_o, 1);
        chk("fifo_head_b", acc_q_op_o, mk(11, 0, 0, 0));
        cyc();
        idle(); #1;
        chk("fifo_head_c", acc_q_op_o, mk(12, 0, 0, 0));
        chk("fifo_c_valid", acc_q_valid_o, 1);
        cyc();
        chk("fifo_empty_valid", acc_q_valid_o, 0);
        chk("fifo_empty_op", acc_q_op_o, 0);

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            offer(3, 1, 3'b000, mk(r, 0, 0, 0)); #1;
            chk("outst_fill", q_ready_o, 1);
            cyc();
        end
        offer(3, 1, 3'b000, mk(6, 0, 0, 0)); #1;
        chk("outst_stall", q_ready_o, 0);
        offer(3, 1, 3'b000, mk(0, 0, 0, 0)); #1;
        chk("outst_rd0_ok", q_ready_o, 1);
        cyc();
        offer(3, 1, 3'b000, mk(6, 0, 0, 0));
        acc_p_valid_i = 1'b1; acc_p_id_i = 5'd1; #1;
        chk("outst_clear_nobypass", q_ready_o, 0);
        cyc();
        offer(3, 1, 3'b000, mk(7, 0, 0, 0));
        acc_p_valid_i = 1'b0; #1;
        chk("outst_after_clear", q_ready_o, 1);
        acc_p_valid_i = 1'b1; acc_p_id_i = 5'd2;
        cyc();
        acc_p_valid_i = 1'b0;
        offer(3, 1, 3'b000, mk(8, 0, 0, 0)); #1;
        chk("outst_net_zero", q_ready_o, 1);
        cyc();
        offer(3, 1, 3'b000, mk(9, 0, 0, 0)); #1;
        chk("outst_full_again", q_ready_o, 0);
        cyc();
        idle();
        cyc();

        // Multiple claimants
        offload_accept_i = 8'b0000_0110; pd_writeback_i = 8'b0000_0100;
        use_rs_i = '0; instr_i = mk(3, 0, 0, 0); q_valid_i = 1'b1; #1;
        chk("multi_accept", accept_o, 1);
        chk("multi_lowest_wb", writeback_o, 0);
        chk("multi_ready", q_ready_o, 1);
        chk("multi_err_pre", multi_accept_err_o, 0);
        cyc();
        idle(); #1;
        chk("multi_err_set", multi_accept_err_o, 1);
        chk("multi_addr", acc_q_addr_o, 1);
        cyc(); cyc();
        chk("multi_err_sticky", multi_accept_err_o, 1);
        chk("multi_drained", acc_q_valid_o, 0);
        instr_i = mk(3, 3, 0, 0); q_valid_i = 1'b1; #1;
        chk("unclaimed_ready", q_ready_o, 1);
        chk("unclaimed_accept", accept_o, 0);
        chk("unclaimed_wb", writeback_o, 0);
        cyc();
        idle(); #1;
        chk("unclaimed_no_push", acc_q_valid_o, 0);

        // Reset mid-operation
        acc_q_ready_i = 1'b0;
        offer(0, 0, 3'b000, mk(1, 0, 0, 0)); cyc();
        offer(0, 0, 3'b000, mk(2, 0, 0, 0)); cyc();
        idle(); #1;
        chk("pre_rst_valid", acc_q_valid_o, 1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0; #1;
        chk("mid_rst_valid", acc_q_valid_o, 0);
        chk("mid_rst_op", acc_q_op_o, 0);
        chk("mid_rst_multi", multi_accept_err_o, 0);
        acc_q_ready_i = 1'b1;
        offer(0, 0, 3'b001, mk(1, 3, 0, 0));
        acc_p_valid_i = 1'b1; acc_p_id_i = 5'd3; acc_p_data_i = 32'hdead_beef; #1;
        chk("mid_rst_pending_clr", q_ready_o, 1);
        chk("stale_p_valid", p_valid_o, 1);
        chk("stale_p_id", p_id_o, 3);
        chk("stale_p_data", p_data_o, 32'hdead_beef);
        cyc();
        acc_p_valid_i = 1'b0;
        for (int r = 10; r <= 13; r++) begin
            offer(4, 1, 3'b000, mk(r, 0, 0, 0)); #1;
            chk("post_rst_fill", q_ready_o, 1);
            cyc();
        end
        offer(4, 1, 3'b000, mk(14, 0, 0, 0)); #1;
        chk("post_rst_outst_stall", q_ready_o, 0);
        idle();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
